dram_port_arbiter: RTL and testbench
====================================

// Module: dram_port_arbiter
// PURPOSE
// - Shares the two ports of the dual-port monitoring RAM (registered read, write-first) among N_REQ requesters.
// - Per cycle: up to two round-robin grants, one per RAM port; same-address hazards blocked; read data routed back.
// - Optional post-reset clear of the whole RAM. Sits between trace writers/host readers and the RAM instance.
// PARAMETERS
// - WORD_SIZE     64   data width, matches RAM
// - ADDR_SIZE     8    address width, matches RAM; >=1
// - WORD_CAPACITY 2**ADDR_SIZE  RAM depth, even
// - N_REQ         4    requesters, 2..16
// PORTS
// - clk         in   1                 single clock, rising edge
// - rst         in   1                 asynchronous, active-high reset
// - req_valid   in   N_REQ             request pending, held until accepted
// - req_we      in   N_REQ             1 = write, 0 = read
// - req_addr    in   N_REQ*ADDR_SIZE   flattened, requester i at [i*ADDR_SIZE +: ADDR_SIZE]
// - req_wdata   in   N_REQ*WORD_SIZE   flattened write data
// - req_ready   out  N_REQ             accept strobe; transfer = valid & ready
// - rsp_valid   out  N_REQ             read data valid for requester i
// - rsp_rdata   out  N_REQ*WORD_SIZE   flattened read data; defined only while rsp_valid[i]
// - ram_we_1/_2     out 1          RAM port 1/2 write enable
// - ram_addr_1/_2   out ADDR_SIZE  RAM port 1/2 address
// - ram_wdata_1/_2  out WORD_SIZE  RAM port 1/2 write data
// - ram_rdata_1/_2  in  WORD_SIZE  RAM port 1/2 registered output
// - init_busy   out  1                 high while clear sequence runs
// BEHAVIOUR
// - States: CLEAR, RUN. Reset -> CLEAR with macro, else RUN. rst mid-CLEAR restarts clear at count 0.
// - Reset values: rr_ptr=0, clr_cnt=0, rsp_valid=0, internal grant regs=0; ram_we_* low in RUN with no grant.
// - RUN arbitration (combinational, same cycle): scan from rr_ptr upward with wrap.
//   first valid -> port 1, next valid -> port 2; ram_* driven from granted requester, req_ready set for it.
// - Hazard: port-2 candidate with same addr as port-1 grant and either one a write -> not granted;
//   scan continues to next valid requester. Two reads of same address are both granted.
// - No valid requests: req_ready=0, ram_we_*=0, rr_ptr unchanged.
// - rr_ptr <= (last granted index + 1) mod N_REQ at each edge with >=1 grant.
// - Read latency 1: accepted read at edge k -> rsp_valid[i]=1 in cycle after k, rsp_rdata from port's ram_rdata.
//   Writes produce no response. Requester granted in consecutive cycles gets back-to-back responses.
// - Write at edge k is visible to reads accepted at edge k+1 or later.
// - In CLEAR: req_ready=0, rsp_valid=0, init_busy=1.
// CONFIGURATION
// - DRAM_ARB_CLEAR_EN defined: after reset, CLEAR writes 0 to all words.
//   port 1 -> addr 2*clr_cnt, port 2 -> addr 2*clr_cnt+1, clr_cnt 0..WORD_CAPACITY/2-1.
//   WORD_CAPACITY/2 cycles, then RUN.
// - Undefined: no CLEAR state or counter, init_busy tied 0, RUN from reset, RAM contents undefined.
// STRUCTURE
// - Package dram_arb_pkg: state enum {CLEAR, RUN}; localparam ID_W = $clog2(N_REQ); grant record type.
// - Sub-module rr_pick: valid mask + start pointer + exclude mask -> first index and found flag.
//   Instantiated twice: port 1; port 2 with port-1 winner and hazard losers excluded.
// - Top: FSM, clear counter, rr_ptr, registered per-port grant id/read flag for response routing.
// TESTING
// - Clear (macro on, ADDR_SIZE=8): release rst -> init_busy high exactly 128 cycles; reads of 0x00 and 0xFF return 0.
// - Single read: req0 writes 0xDEAD at 0x10; next cycle req0 reads 0x10 -> rsp_valid[0] one cycle later, data 0xDEAD.
// - Fairness: all 4 valid, all reads, held -> grants {0,1},{2,3},{0,1}...; no requester waits more than 2 cycles.
// - Hazard: rr_ptr=0, req0 write 0x20, req1 read 0x20, req2 read 0x30 -> req0 port 1, req2 port 2, req1 next cycle, reads new data.
// - Dual read same addr: req1 and req3 read 0x05 (=0x77) -> both ready same cycle, both rsp_rdata 0x77 one cycle later.
// - Reset mid-CLEAR at count 40 -> clr_cnt back to 0, full 128-cycle clear, no req_ready asserted meanwhile.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// Shared types for the dual-port RAM arbiter: FSM state, grant-id width and
// the per-port grant record used to route registered read data back.
package dram_arb_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } arb_state_t;

   // Grant ids are sized for the largest supported requester count (16).
   localparam int N_REQ_MAX = 16;
   localparam int ID_W      = $clog2(N_REQ_MAX);

   typedef struct packed {
      logic            vld;
      logic            rd;
      logic [ID_W-1:0] id;
   } grant_t;

endpackage

// File: rtl/dram_port_arbiter_rr_pick.sv
// Round-robin picker: returns the first requester at or after 'start'
// (with wrap) that is valid and not excluded.
module rr_pick
   import dram_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]    valid,
   input  logic [ID_W-1:0] start,
   input  logic [N-1:0]    exclude,
   output logic [ID_W-1:0] idx,
   output logic            found
);

   logic [N-1:0] cand;
   int           pos;

   // NOTE: every output gets a default before the scan so no latch is inferred.
   always_comb begin
      cand  = valid & ~exclude;
      found = 1'b0;
      idx   = '0;
      pos   = 0;
      for (int k = 0; k < N; k++) begin
         pos = (int'(start) + k) % N;
         if (!found && cand[pos]) begin
            found = 1'b1;
            idx   = ID_W'(pos);
         end
      end
   end

endmodule

// File: rtl/dram_port_arbiter.sv
// Two-port round-robin arbiter in front of a dual-port registered-read RAM.
// Define DRAM_ARB_CLEAR_EN to zero the whole RAM after every reset.
module dram_port_arbiter
   import dram_arb_pkg::*;
#(
   parameter int WORD_SIZE     = 64,
   parameter int ADDR_SIZE     = 8,
   parameter int WORD_CAPACITY = 2 ** ADDR_SIZE,
   parameter int N_REQ         = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ-1:0]           req_we,
   input  logic [N_REQ*ADDR_SIZE-1:0] req_addr,
   input  logic [N_REQ*WORD_SIZE-1:0] req_wdata,
   output logic [N_REQ-1:0]           req_ready,
   output logic [N_REQ-1:0]           rsp_valid,
   output logic [N_REQ*WORD_SIZE-1:0] rsp_rdata,
   output logic                       ram_we_1,
   output logic [ADDR_SIZE-1:0]       ram_addr_1,
   output logic [WORD_SIZE-1:0]       ram_wdata_1,
   input  logic [WORD_SIZE-1:0]       ram_rdata_1,
   output logic                       ram_we_2,
   output logic [ADDR_SIZE-1:0]       ram_addr_2,
   output logic [WORD_SIZE-1:0]       ram_wdata_2,
   input  logic [WORD_SIZE-1:0]       ram_rdata_2,
   output logic                       init_busy
);

   localparam int AW = ADDR_SIZE;
   localparam int DW = WORD_SIZE;

   logic                 run;
   logic [ID_W-1:0]      rr_ptr;
   logic [N_REQ-1:0]     valid_run;
   logic [N_REQ-1:0]     excl2;
   logic [ID_W-1:0]      idx1, idx2;
   logic                 found1, found2;
   logic [AW-1:0]        addr1, addr2;
   logic [DW-1:0]        wdata1, wdata2;
   logic                 we1, we2;
   grant_t               g1_q, g2_q;

`ifdef DRAM_ARB_CLEAR_EN
   localparam int CNT_W     = (ADDR_SIZE > 1) ? ADDR_SIZE - 1 : 1;
   localparam int LAST_PAIR = WORD_CAPACITY / 2 - 1;

   arb_state_t       state_q, state_d;
   logic [CNT_W-1:0] clr_cnt;

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CLEAR;
         clr_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == CLEAR) clr_cnt <= clr_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q == CLEAR && clr_cnt == CNT_W'(LAST_PAIR)) state_d = RUN;
   end

   assign run       = (state_q == RUN);
   assign init_busy = ~run;
`else
   assign run       = 1'b1;
   assign init_busy = 1'b0;
`endif

   assign valid_run = run ? req_valid : '0;

   rr_pick #(.N(N_REQ)) u_pick1 (
      .valid   (valid_run),
      .start   (rr_ptr),
      .exclude ('0),
      .idx     (idx1),
      .found   (found1)
   );

   // Port 2 skips the port-1 winner and any same-address pair involving a write.
   always_comb begin
      excl2 = '0;
      for (int i = 0; i < N_REQ; i++) begin
         excl2[i] = (ID_W'(i) == idx1) ||
                    ((req_addr[i*AW +: AW] == addr1) && (req_we[i] || we1));
      end
   end

   rr_pick #(.N(N_REQ)) u_pick2 (
      .valid   (valid_run),
      .start   (rr_ptr),
      .exclude (excl2),
      .idx     (idx2),
      .found   (found2)
   );

   always_comb begin
      addr1  = '0;
      wdata1 = '0;
      we1    = 1'b0;
      addr2  = '0;
      wdata2 = '0;
      we2    = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (ID_W'(i) == idx1) begin
            addr1  = req_addr[i*AW +: AW];
            wdata1 = req_wdata[i*DW +: DW];
            we1    = req_we[i];
         end
         if (ID_W'(i) == idx2) begin
            addr2  = req_addr[i*AW +: AW];
            wdata2 = req_wdata[i*DW +: DW];
            we2    = req_we[i];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = (found1 && idx1 == ID_W'(i)) || (found2 && idx2 == ID_W'(i));
      end
   end

   always_comb begin
      ram_we_1    = found1 & we1;
      ram_addr_1  = addr1;
      ram_wdata_1 = wdata1;
      ram_we_2    = found2 & we2;
      ram_addr_2  = addr2;
      ram_wdata_2 = wdata2;
`ifdef DRAM_ARB_CLEAR_EN
      if (!run) begin
         ram_we_1    = 1'b1;
         ram_addr_1  = AW'({clr_cnt, 1'b0});
         ram_wdata_1 = '0;
         ram_we_2    = 1'b1;
         ram_addr_2  = AW'({clr_cnt, 1'b1});
         ram_wdata_2 = '0;
      end
`endif
   end

   function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] i);
      if (int'(i) == N_REQ - 1) return '0;
      return i + ID_W'(1);
   endfunction

   // The pointer moves past the last requester granted in scan order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (found2) begin
         rr_ptr <= wrap_inc(idx2);
      end else if (found1) begin
         rr_ptr <= wrap_inc(idx1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         g1_q <= '0;
         g2_q <= '0;
      end else begin
         g1_q <= '{vld: found1, rd: ~we1, id: idx1};
         g2_q <= '{vld: found2, rd: ~we2, id: idx2};
      end
   end

   // RAM read data arrives one cycle after the grant; route it by the stored id.
   always_comb begin
      rsp_valid = '0;
      rsp_rdata = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (g1_q.vld && g1_q.rd && g1_q.id == ID_W'(i)) begin
            rsp_valid[i]          = 1'b1;
            rsp_rdata[i*DW +: DW] = ram_rdata_1;
         end
         if (g2_q.vld && g2_q.rd && g2_q.id == ID_W'(i)) begin
            rsp_valid[i]          = 1'b1;
            rsp_rdata[i*DW +: DW] = ram_rdata_2;
         end
      end
   end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter with a behavioural write-first RAM.
// Clear-sequence checks are compiled in when DRAM_ARB_CLEAR_EN is defined.
module tb_dram_port_arbiter;

   localparam int N  = 4;
   localparam int AW = 8;
   localparam int DW = 64;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_we;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    rsp_valid;
   logic [N*DW-1:0] rsp_rdata;
   logic            ram_we_1, ram_we_2;
   logic [AW-1:0]   ram_addr_1, ram_addr_2;
   logic [DW-1:0]   ram_wdata_1, ram_wdata_2;
   logic [DW-1:0]   ram_rdata_1, ram_rdata_2;
   logic            init_busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dram_port_arbiter #(
      .WORD_SIZE(DW), .ADDR_SIZE(AW), .WORD_CAPACITY(256), .N_REQ(N)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .ram_we_1(ram_we_1), .ram_addr_1(ram_addr_1), .ram_wdata_1(ram_wdata_1), .ram_rdata_1(ram_rdata_1),
      .ram_we_2(ram_we_2), .ram_addr_2(ram_addr_2), .ram_wdata_2(ram_wdata_2), .ram_rdata_2(ram_rdata_2),
      .init_busy(init_busy)
   );

   // Dual-port RAM, registered read, write-first.
   logic [DW-1:0] mem [0:255];
   always @(posedge clk) begin
      if (ram_we_1) mem[ram_addr_1] <= ram_wdata_1;
      if (ram_we_2) mem[ram_addr_2] <= ram_wdata_2;
      ram_rdata_1 <= ram_we_1 ? ram_wdata_1 : mem[ram_addr_1];
      ram_rdata_2 <= ram_we_2 ? ram_wdata_2 : mem[ram_addr_2];
   end

   typedef struct {
      logic [3:0]  valid;
      logic [3:0]  we;
      logic [31:0] addr;    // {a3, a2, a1, a0}
      logic [3:0]  ready;
      logic        we1;
      logic [7:0]  a1;
      logic        we2;
      logic [7:0]  a2;
      logic [3:0]  rsp;     // rsp_valid seen in this cycle
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] v, input logic [3:0] w, input logic [31:0] a);
      req_valid = v;
      req_we    = w;
      req_addr  = a;
   endtask

   task automatic set_wd(input int i, input logic [63:0] d);
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [63:0] rd_of(input int i);
      return rsp_rdata[i*DW +: DW];
   endfunction

`ifdef DRAM_ARB_CLEAR_EN
   task automatic run_clear(input int limit, output int cyc, output logic saw_ready);
      cyc       = 0;
      saw_ready = 1'b0;
      while (init_busy && cyc < limit) begin
         if (req_ready != '0) saw_ready = 1'b1;
         cyc++;
         next_cycle();
      end
   endtask
`endif

   vec_t vecs[11];

   initial begin
      vecs[0]  = '{4'h0, 4'h0, 32'h04030201, 4'h0, 1'b0, 8'h00, 1'b0, 8'h00, 4'h0};
      vecs[1]  = '{4'hF, 4'h0, 32'h04030201, 4'h3, 1'b0, 8'h01, 1'b0, 8'h02, 4'h0};
      vecs[2]  = '{4'hF, 4'h0, 32'h04030201, 4'hC, 1'b0, 8'h03, 1'b0, 8'h04, 4'h3};
      vecs[3]  = '{4'hF, 4'h0, 32'h04030201, 4'h3, 1'b0, 8'h01, 1'b0, 8'h02, 4'hC};
      vecs[4]  = '{4'h1, 4'h0, 32'h04030201, 4'h1, 1'b0, 8'h01, 1'b0, 8'h00, 4'h3};
      vecs[5]  = '{4'h9, 4'h0, 32'h04030201, 4'h9, 1'b0, 8'h04, 1'b0, 8'h01, 4'h1};
      vecs[6]  = '{4'h6, 4'h6, 32'h04090901, 4'h2, 1'b1, 8'h09, 1'b0, 8'h00, 4'h9};
      vecs[7]  = '{4'h0, 4'h0, 32'h04090901, 4'h0, 1'b0, 8'h00, 1'b0, 8'h00, 4'h0};
      vecs[8]  = '{4'h4, 4'h0, 32'h04070201, 4'h4, 1'b0, 8'h07, 1'b0, 8'h00, 4'h0};
      vecs[9]  = '{4'hA, 4'h0, 32'h09070901, 4'hA, 1'b0, 8'h09, 1'b0, 8'h09, 4'h4};
      vecs[10] = '{4'h0, 4'h0, 32'h09070901, 4'h0, 1'b0, 8'h00, 1'b0, 8'h00, 4'hA};

      drive(4'h0, 4'h0, 32'h0);
      for (int i = 0; i < N; i++) set_wd(i, 64'hA0 + 64'(i));

      // Reset state
      #12;
      check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      check("rst_req_ready", 64'(req_ready), 64'h0);
`ifdef DRAM_ARB_CLEAR_EN
      check("rst_init_busy", 64'(init_busy), 64'h1);
`else
      check("rst_init_busy", 64'(init_busy), 64'h0);
      check("rst_ram_we", 64'({ram_we_1, ram_we_2}), 64'h0);
`endif
      @(negedge clk);
      rst = 1'b0;
      #1;

`ifdef DRAM_ARB_CLEAR_EN
      begin
         int   cyc;
         logic saw;
         drive(4'hF, 4'h0, 32'h0);
         run_clear(40, cyc, saw);
         check("clear_partial_cycles", 64'(cyc), 64'd40);
         rst = 1'b1;
         #1;
         check("clear_rst_busy", 64'(init_busy), 64'h1);
         @(negedge clk);
         rst = 1'b0;
         #1;
         run_clear(1000, cyc, saw);
         check("clear_cycles", 64'(cyc), 64'd128);
         check("clear_no_ready", 64'(saw), 64'h0);
         drive(4'h0, 4'h0, 32'h0);
         #1;
         check("clear_done_busy", 64'(init_busy), 64'h0);
      end
`endif

      // Table: round-robin, fairness, idle, hazard and dual-read arbitration
      for (int v = 0; v < 11; v++) begin
         drive(vecs[v].valid, vecs[v].we, vecs[v].addr);
         #1;
         check($sformatf("v%0d_ready", v), 64'(req_ready), 64'(vecs[v].ready));
         check($sformatf("v%0d_rsp", v), 64'(rsp_valid), 64'(vecs[v].rsp));
         check($sformatf("v%0d_we", v), 64'({ram_we_1, ram_we_2}), 64'({vecs[v].we1, vecs[v].we2}));
         if ($countones(vecs[v].ready) >= 1)
            check($sformatf("v%0d_a1", v), 64'(ram_addr_1), 64'(vecs[v].a1));
         if ($countones(vecs[v].ready) == 2)
            check($sformatf("v%0d_a2", v), 64'(ram_addr_2), 64'(vecs[v].a2));
         if (vecs[v].we1)
            check($sformatf("v%0d_wd1", v), ram_wdata_1, 64'hA1);
         if (v < 10) next_cycle();
      end
      check("v10_rd1", rd_of(1), 64'hA1);
      check("v10_rd3", rd_of(3), 64'hA1);
      next_cycle();

      // Single write then read by req0
      set_wd(0, 64'hDEAD);
      drive(4'h1, 4'h1, 32'h00000010);
      #1;
      check("wr_ready", 64'(req_ready), 64'h1);
      next_cycle();
      drive(4'h1, 4'h0, 32'h00000010);
      #1;
      check("rd_ready", 64'(req_ready), 64'h1);
      check("rd_no_rsp_for_write", 64'(rsp_valid), 64'h0);
      next_cycle();
      drive(4'h0, 4'h0, 32'h0);
      #1;
      check("rd_rsp_valid", 64'(rsp_valid), 64'h1);
      check("rd_rsp_data", rd_of(0), 64'hDEAD);
      next_cycle();
      check("rd_rsp_done", 64'(rsp_valid), 64'h0);

      // Bring rr_ptr to 0, then write/read hazard on 0x20
      drive(4'h8, 4'h0, 32'h10000000);
      #1;
      check("rr_align_ready", 64'(req_ready), 64'h8);
      next_cycle();
      set_wd(0, 64'hBEEF);
      drive(4'h7, 4'h1, 32'h00302020);
      #1;
      check("haz_ready", 64'(req_ready), 64'h5);
      check("haz_we", 64'({ram_we_1, ram_we_2}), 64'h2);
      check("haz_a1", 64'(ram_addr_1), 64'h20);
      check("haz_a2", 64'(ram_addr_2), 64'h30);
      check("haz_wd1", ram_wdata_1, 64'hBEEF);
      check("haz_prev_rsp", 64'(rsp_valid), 64'h8);
      check("haz_prev_data", rd_of(3), 64'hDEAD);
      next_cycle();
      drive(4'h2, 4'h0, 32'h00302020);
      #1;
      check("haz_retry_ready", 64'(req_ready), 64'h2);
      check("haz_retry_a1", 64'(ram_addr_1), 64'h20);
      check("haz_rsp2", 64'(rsp_valid), 64'h4);
      next_cycle();
      drive(4'h0, 4'h0, 32'h0);
      #1;
      check("haz_rsp1", 64'(rsp_valid), 64'h2);
      check("haz_rsp1_data", rd_of(1), 64'hBEEF);
      next_cycle();

      // Two reads of the same address share the cycle
      set_wd(0, 64'h77);
      drive(4'h1, 4'h1, 32'h00000005);
      #1;
      check("dual_wr_ready", 64'(req_ready), 64'h1);
      next_cycle();
      drive(4'hA, 4'h0, 32'h05000500);
      #1;
      check("dual_ready", 64'(req_ready), 64'hA);
      check("dual_a1", 64'(ram_addr_1), 64'h05);
      check("dual_a2", 64'(ram_addr_2), 64'h05);
      next_cycle();
      drive(4'h0, 4'h0, 32'h0);
      #1;
      check("dual_rsp", 64'(rsp_valid), 64'hA);
      check("dual_rd1", rd_of(1), 64'h77);
      check("dual_rd3", rd_of(3), 64'h77);
      next_cycle();

`ifdef DRAM_ARB_CLEAR_EN
      // Cleared words read back as zero
      drive(4'h3, 4'h0, 32'h0000FF00);
      #1;
      check("clr_rd_ready", 64'(req_ready), 64'h3);
      next_cycle();
      drive(4'h0, 4'h0, 32'h0);
      #1;
      check("clr_rd_rsp", 64'(rsp_valid), 64'h3);
      check("clr_rd_00", rd_of(0), 64'h0);
      check("clr_rd_ff", rd_of(1), 64'h0);
      next_cycle();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
